// File: rtl/spi_result_tx.sv
// SPI target transmitter (mode 0): one-entry holding register feeding an
// MSB-first shift register clocked by synchronized host SCLK edges.
module spi_result_tx #(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCLK,
    input  logic       spi_cs_n,
    output logic       CIPO,
    output logic       cipo_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       byte_sent,
    output logic       tx_abort,
    output logic       underrun
);

    typedef enum logic [1:0] {IDLE, ARM, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic [SYNC_STAGES:0]   vld_pipe;
    logic                   cs_qual;
    logic [7:0]             hold;
    logic                   hold_full;
    logic [7:0]             shift_reg;
    logic [2:0]             bit_cnt;
    logic                   byte_done;

    logic       sclk_s, cs_s;
    logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic       reload_evt, consume, load_acc;
    logic [7:0] reload_src;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    // A falling cs_n only counts once cs_n has been seen high with a flushed
    // synchronizer, so a pin held low across reset never starts a transfer.
    assign cs_fall   = ~cs_s & cs_d & cs_qual;

    assign reload_evt = ((state == ARM) && !cs_rise) ||
                        ((state == SHIFT) && !cs_rise && sclk_fall &&
                         (bit_cnt == 3'd0) && byte_done);
    assign consume    = reload_evt & hold_full;
    assign load_acc   = tx_load & (~hold_full | consume);
    assign reload_src = hold_full ? hold : IDLE_BYTE;
    assign tx_ready   = ~hold_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sclk_sync <= '0;
            cs_sync   <= '1;
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            vld_pipe  <= '0;
            cs_qual   <= 1'b0;
            hold      <= 8'h00;
            hold_full <= 1'b0;
            shift_reg <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_done <= 1'b0;
            CIPO      <= 1'b0;
            cipo_oe   <= 1'b0;
            byte_sent <= 1'b0;
            tx_abort  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            vld_pipe  <= {vld_pipe[SYNC_STAGES-1:0], 1'b1};
            if (vld_pipe[SYNC_STAGES] && cs_s)
                cs_qual <= 1'b1;

            byte_sent <= 1'b0;
            tx_abort  <= 1'b0;

            if (load_acc) begin
                hold      <= tx_data;
                hold_full <= 1'b1;
            end else if (consume) begin
                hold_full <= 1'b0;
            end

            // Substitution wins over a same-cycle load: that load is for the next byte.
            if (reload_evt && !hold_full)
                underrun <= 1'b1;
            else if (load_acc)
                underrun <= 1'b0;

            case (state)
                IDLE: begin
                    CIPO    <= 1'b0;
                    cipo_oe <= 1'b0;
                    if (cs_fall) begin
                        state   <= ARM;
                        cipo_oe <= 1'b1;
                    end
                end
                ARM: begin
                    if (cs_rise) begin
                        state   <= IDLE;
                        CIPO    <= 1'b0;
                        cipo_oe <= 1'b0;
                    end else begin
                        shift_reg <= reload_src;
                        CIPO      <= reload_src[7];
                        bit_cnt   <= 3'd0;
                        byte_done <= 1'b0;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state     <= IDLE;
                        CIPO      <= 1'b0;
                        cipo_oe   <= 1'b0;
                        tx_abort  <= (bit_cnt != 3'd0);
                        bit_cnt   <= 3'd0;
                        byte_done <= 1'b0;
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_sent <= 1'b1;
                            byte_done <= 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != 3'd0) begin
                            shift_reg <= {shift_reg[6:0], 1'b0};
                            CIPO      <= shift_reg[6];
                        end else if (byte_done) begin
                            shift_reg <= reload_src;
                            CIPO      <= reload_src[7];
                            byte_done <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_result_tx.sv
// Directed bench for spi_result_tx: a mode-0 host model drives SCLK at clk/8.
module tb_spi_result_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       SCLK = 1'b0;
    logic       spi_cs_n = 1'b1;
    logic       CIPO, cipo_oe, tx_ready, byte_sent, tx_abort, underrun;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;

    int total = 0;
    int bad   = 0;
    int bs_cnt = 0;
    int ab_cnt = 0;

    spi_result_tx #(.IDLE_BYTE(8'hFF), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .SCLK(SCLK), .spi_cs_n(spi_cs_n),
        .CIPO(CIPO), .cipo_oe(cipo_oe), .tx_data(tx_data), .tx_load(tx_load),
        .tx_ready(tx_ready), .byte_sent(byte_sent), .tx_abort(tx_abort),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (byte_sent) bs_cnt <= bs_cnt + 1;
        if (tx_abort)  ab_cnt <= ab_cnt + 1;
    end

    task automatic do_reset();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic load(input logic [7:0] b);
        @(negedge clk);
        tx_data = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        @(negedge clk) spi_cs_n = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic cs_high();
        @(negedge clk) spi_cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Host samples CIPO as it raises SCLK; with end_cs the final SCLK fall
    // and the cs_n rise happen together.
    task automatic xfer(input int n, input bit end_cs, output logic [15:0] rx);
        rx = 16'h0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx   = {rx[14:0], CIPO};
            SCLK = 1'b1;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            if (end_cs && i == n - 1) spi_cs_n = 1'b1;
            repeat (3) @(negedge clk);
        end
        if (end_cs) repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if ({CIPO, cipo_oe, tx_ready, byte_sent, tx_abort, underrun} !== 6'b001000) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=001000",
                     {CIPO, cipo_oe, tx_ready, byte_sent, tx_abort, underrun});
        end
        rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single();
        logic [15:0] rx;
        int bs0;
        do_reset();
        bs0 = bs_cnt;
        load(8'h07);
        total++;
        if (tx_ready !== 1'b0) begin bad++; $display("FAIL single_ready_after_load got=%b want=0", tx_ready); end
        cs_low();
        total++;
        if (cipo_oe !== 1'b1) begin bad++; $display("FAIL single_oe got=%b want=1", cipo_oe); end
        xfer(8, 1'b1, rx);
        total++;
        if (rx[7:0] !== 8'h07) begin bad++; $display("FAIL single_data got=%h want=07", rx[7:0]); end
        total++;
        if (bs_cnt - bs0 != 1) begin bad++; $display("FAIL single_byte_sent got=%0d want=1", bs_cnt - bs0); end
        total++;
        if ({tx_ready, underrun, cipo_oe} !== 3'b100) begin
            bad++; $display("FAIL single_flags got=%b want=100", {tx_ready, underrun, cipo_oe});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] rx;
        int bs0;
        do_reset();
        bs0 = bs_cnt;
        load(8'hA5);
        cs_low();
        fork
            xfer(16, 1'b1, rx);
            begin
                int k = 0;
                while (!byte_sent && k < 400) begin @(negedge clk); k++; end
                total++;
                if (!byte_sent) begin bad++; $display("FAIL b2b_first_byte_sent got=timeout want=pulse"); end
                @(negedge clk);
                tx_data = 8'h3C;
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
        join
        total++;
        if (rx !== 16'hA53C) begin bad++; $display("FAIL b2b_data got=%h want=a53c", rx); end
        total++;
        if (bs_cnt - bs0 != 2) begin bad++; $display("FAIL b2b_byte_sent got=%0d want=2", bs_cnt - bs0); end
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL b2b_underrun got=%b want=0", underrun); end
    endtask

    task automatic test_underrun();
        logic [15:0] rx;
        do_reset();
        cs_low();
        xfer(8, 1'b1, rx);
        total++;
        if (rx[7:0] !== 8'hFF) begin bad++; $display("FAIL underrun_data got=%h want=ff", rx[7:0]); end
        total++;
        if (underrun !== 1'b1) begin bad++; $display("FAIL underrun_set got=%b want=1", underrun); end
        load(8'h01);
        total++;
        if (underrun !== 1'b0) begin bad++; $display("FAIL underrun_clear got=%b want=0", underrun); end
    endtask

    task automatic test_abort();
        logic [15:0] rx;
        int bs0, ab0;
        do_reset();
        bs0 = bs_cnt;
        ab0 = ab_cnt;
        load(8'hC3);
        cs_low();
        xfer(3, 1'b0, rx);
        total++;
        if (rx[2:0] !== 3'b110) begin bad++; $display("FAIL abort_bits got=%b want=110", rx[2:0]); end
        cs_high();
        total++;
        if (ab_cnt - ab0 != 1) begin bad++; $display("FAIL abort_pulse got=%0d want=1", ab_cnt - ab0); end
        total++;
        if (bs_cnt != bs0) begin bad++; $display("FAIL abort_no_byte_sent got=%0d want=0", bs_cnt - bs0); end
        total++;
        if ({tx_ready, cipo_oe} !== 2'b10) begin
            bad++; $display("FAIL abort_state got=%b want=10", {tx_ready, cipo_oe});
        end
    endtask

    task automatic test_ignored_load();
        logic [15:0] rx;
        do_reset();
        load(8'h55);
        load(8'hAA);
        total++;
        if (tx_ready !== 1'b0) begin bad++; $display("FAIL ignore_ready got=%b want=0", tx_ready); end
        cs_low();
        xfer(8, 1'b1, rx);
        total++;
        if (rx[7:0] !== 8'h55) begin bad++; $display("FAIL ignore_data got=%h want=55", rx[7:0]); end
        total++;
        if (tx_ready !== 1'b1) begin bad++; $display("FAIL ignore_empty got=%b want=1", tx_ready); end
    endtask

    task automatic test_latency();
        int n = 0;
        int ab0;
        do_reset();
        ab0 = ab_cnt;
        load(8'h80);
        @(negedge clk) spi_cs_n = 1'b0;
        while (CIPO !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
        total++;
        if (n > 4) begin bad++; $display("FAIL latency_cycles got=%0d want<=4", n); end
        cs_high();
        total++;
        if (ab_cnt != ab0) begin bad++; $display("FAIL latency_no_abort got=%0d want=0", ab_cnt - ab0); end
    endtask

    task automatic test_reset_mid_byte();
        logic [15:0] rx;
        int bs0;
        do_reset();
        load(8'h0F);
        cs_low();
        xfer(4, 1'b0, rx);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({CIPO, cipo_oe, tx_ready, byte_sent, tx_abort, underrun} !== 6'b001000) begin
            bad++;
            $display("FAIL midrst_outputs got=%b want=001000",
                     {CIPO, cipo_oe, tx_ready, byte_sent, tx_abort, underrun});
        end
        rst = 1'b0;
        bs0 = bs_cnt;
        repeat (6) @(negedge clk);
        xfer(8, 1'b0, rx);
        total++;
        if (bs_cnt != bs0) begin bad++; $display("FAIL midrst_no_byte_sent got=%0d want=0", bs_cnt - bs0); end
        total++;
        if (cipo_oe !== 1'b0) begin bad++; $display("FAIL midrst_oe got=%b want=0", cipo_oe); end
        cs_high();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_underrun();
        test_abort();
        test_ignored_load();
        test_latency();
        test_reset_mid_byte();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
